// File: rtl/float_pkg.sv
// Shared definitions for the integer-to-float converter.
// Provides the IEEE-754 single-precision field layout and the FSM state
// encoding used by int_to_float_serial.
package float_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;

  // Bit positions inside a 32-bit float word {sign, exp, mant}
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ABS_ENC   = 3'd1;
  localparam logic [2:0] ST_NORM_ENC  = 3'd2;
  localparam logic [2:0] ST_ROUND_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ABS   = ST_ABS_ENC,
    ST_NORM  = ST_NORM_ENC,
    ST_ROUND = ST_ROUND_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

endpackage

// File: rtl/int_to_float_serial_round.sv
// round_nearest_even: combinational round-to-nearest-even of a normalised
// 24-bit significand.
//   sig_i    : significand with the hidden bit at [23]
//   guard_i  : first bit below the significand
//   sticky_i : OR of every bit below the guard
//   exp_i    : biased exponent before rounding
//   mant_o   : 23-bit stored mantissa after rounding
//   exp_o    : exponent, incremented when rounding carries out
module round_nearest_even
  import float_pkg::*;
(
  input  logic [MANT_W:0]   sig_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [EXP_W-1:0]  exp_o
);

  logic              round_up;
  logic [MANT_W+1:0] sum;
  logic              carry;
  logic              unused_hidden_bit;

  // Ties go up only when the kept LSB is odd
  assign round_up = guard_i & (sticky_i | sig_i[0]);
  assign sum      = {1'b0, sig_i} + {{(MANT_W+1){1'b0}}, round_up};
  assign carry    = sum[MANT_W+1];

  // On carry the low bits of sum are already zero, so the mantissa needs no
  // special case; the new hidden bit is implied by the float format.
  assign mant_o            = sum[MANT_W-1:0];
  assign unused_hidden_bit = sum[MANT_W];
  assign exp_o             = exp_i + {{(EXP_W-1){1'b0}}, carry};

endmodule

// File: rtl/int_to_float_serial.sv
// int_to_float_serial: signed integer to IEEE-754 single-precision float,
// round to nearest even, normalising one bit per cycle.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data valid
//   in_ready  : converter idle and accepting input
//   in_data   : WIDTH-bit two's-complement integer
//   out_valid : out_data holds a result
//   out_ready : consumer accepts result
//   out_data  : float {sign, exp[7:0], mant[22:0]}
module int_to_float_serial
  import float_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data
);

  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FLOAT_BIAS + WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [31:0]        out_q, out_d;

  logic [WIDTH-1:0]   abs_val;
  logic [WIDTH+24:0]  ext;
  logic [MANT_W:0]    sig;
  logic               guard;
  logic               sticky;
  logic [MANT_W-1:0]  mant_rnd;
  logic [EXP_W-1:0]   exp_rnd;

  // Negation wraps the most negative value onto 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  assign abs_val = mag_q[WIDTH-1] ? (~mag_q + WIDTH'(1)) : mag_q;

  // Zero padding below the magnitude lets narrow WIDTHs share the same
  // significand/guard/sticky slicing (padding contributes no rounding).
  assign ext    = {mag_q, 25'b0};
  assign sig    = ext[WIDTH+24 -: MANT_W+1];
  assign guard  = ext[WIDTH];
  assign sticky = |ext[WIDTH-1:0];

  round_nearest_even u_round (
    .sig_i    (sig),
    .guard_i  (guard),
    .sticky_i (sticky),
    .exp_i    (exp_q),
    .mant_o   (mant_rnd),
    .exp_o    (exp_rnd)
  );

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mag_d   = in_data;
          state_d = ST_ABS;
        end
      end
      ST_ABS: begin
        sign_d = mag_q[WIDTH-1];
        mag_d  = abs_val;
        exp_d  = EXP_INIT;
        // Zero skips normalisation; ROUND turns it into +0 so both paths
        // load out_data from the same place.
        state_d = (abs_val == '0) ? ST_ROUND : ST_NORM;
      end
      ST_NORM: begin
        if (mag_q[WIDTH-1]) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ST_ROUND: begin
        // A clear MSB here can only mean the input was zero
        if (mag_q[WIDTH-1]) begin
          out_d[SIGN_BIT]         = sign_q;
          out_d[EXP_MSB:EXP_LSB]  = exp_rnd;
          out_d[MANT_MSB:0]       = mant_rnd;
        end else begin
          out_d = '0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_int_to_float_serial.sv
module tb_int_to_float_serial;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;

  int n_tests;
  int n_fail;

  int_to_float_serial #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one input and let the handshake happen at the next edge (E0)
  task automatic start(input logic [31:0] d);
    check("start_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after E0 until out_valid is seen, then check the result
  task automatic wait_result(input string tag, input logic [31:0] exp_data, input int exp_lat);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 100);
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_data"}, out_data, exp_data);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_idle", in_ready, 1'b1);
  endtask

  task automatic convert(input string tag, input logic [31:0] d,
                         input logic [31:0] exp_data, input int exp_lat);
    start(d);
    wait_result(tag, exp_data, exp_lat);
    take_result();
  endtask

  initial begin
    logic [31:0] held;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: value, expected float, expected latency (k+3 or 2)
    convert("one",     32'h0000_0001, 32'h3F80_0000, 34);
    convert("neg_one", 32'hFFFF_FFFF, 32'hBF80_0000, 34);
    convert("most_neg",32'h8000_0000, 32'hCF00_0000, 3);
    convert("zero",    32'h0000_0000, 32'h0000_0000, 2);
    convert("tie_even",32'd16777217,  32'h4B80_0000, 10);
    convert("tie_up",  32'd16777219,  32'h4B80_0002, 10);
    convert("carry",   32'h7FFF_FFFF, 32'h4F00_0000, 4);
    convert("five",    32'd5,         32'h40A0_0000, 32);

    // Backpressure: result must hold while out_ready is low
    start(32'd16777219);
    wait_result("bp", 32'h4B80_0002, 10);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", out_data, held);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_to_idle_in_ready", in_ready, 1'b1);
    check("bp_to_idle_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 1'b0);
    wait_result("bp_next", 32'h40A0_0000, 32);
    take_result();

    // Reset mid-normalisation; out_data still holds the previous result
    start(32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_out_data", out_data, 32'h0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    convert("post_rst_five", 32'd5, 32'h40A0_0000, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
